dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates a single-port 16-bit data memory between two requesters.
  - Port 0: CPU load/store path.
  - Port 1: debug/DMA loader.
- Sits between the requesters and the data memory. Drives the memory write-enable, address and write-data lines.
- Sequences each access through a small FSM. Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, memory access cycles per transfer (legal range 1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 completion pulse.
- rdata0  out  DW  port 0 read data; valid when ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_wmem  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data (combinational from mem_addr).
- busy  out  1  high in ACCESS and DONE states.
- gnt_id  out  1  index of the current or last granted port.

Behaviour:
- Reset values (asynchronous, while RESET=1):
  - State IDLE.
  - All outputs 0: ack0/1, rdata0/1, mem_wmem, mem_addr, mem_wdata, busy, gnt_id.
  - Round-robin pointer = 1, so port 0 wins the first tie.
- All outputs are registered.
- States:
  - IDLE: no access in progress.
    - If any req is high, select a winner and latch we/addr/wdata into internal registers.
    - Drive mem_addr/mem_wdata from those registers, load cnt=MEM_LAT-1, go ACCESS.
  - ACCESS: memory lines held stable from the latched copy.
    - cnt decrements each cycle.
    - When cnt==0:
      - For a write, mem_wmem=1 for exactly this one cycle.
      - For a read, mem_rdata is captured into the winner's rdata register.
      - Go to DONE.
  - DONE:
    - ackN=1 for the winner for exactly one cycle. rdataN holds its value.
    - mem_wmem=0. Go IDLE.
- Arbitration (round-robin):
  - Both req high in IDLE: grant the port not equal to the pointer.
  - Pointer updates to the winner on grant.
  - Only one req high: grant that port.
- Latency:
  - Request sampled at IDLE edge k → ack at cycle k+MEM_LAT+1.
  - Throughput: one access per MEM_LAT+2 cycles, because DONE always returns to IDLE.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack.
  - Changes to a granted port's inputs after grant are ignored, since the values are latched.
  - A requester may re-assert req in the cycle after ack. It is then arbitrated normally in IDLE.
- rdataN updates only on a read completion of port N; otherwise it holds its last value.
- Write completion leaves rdataN unchanged.
- busy=1 in ACCESS and DONE states.
- gnt_id updates at grant and holds until the next grant.
- A req dropped before grant is never served.
- A req dropped after grant: the access completes and ack still pulses.
- RESET mid-ACCESS:
  - Immediate return to IDLE.
  - mem_wmem forced 0; an unfinished write is not performed.
  - No ack is issued.
- No address range checking; addresses pass through unmodified.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIORITY_EN.
- Defined:
  - Port 0 has fixed priority whenever both req are high.
  - The round-robin pointer is unused.
  - Port 1 is served only when req0=0 in IDLE.
- Undefined: round-robin as above.

Test Plan:
- Single read: mem[0x0010]=0xBEEF; req0=1, we0=0, addr0=0x0010 at cycle 0 → mem_addr=0x0010 from cycle 1; ack0=1 and rdata0=0xBEEF at cycle 2 (MEM_LAT=1); ack1 stays 0.
- Single write: req1=1, we1=1, addr1=0x0004, wdata1=0x1234 → mem_wmem high for exactly 1 cycle with mem_addr=0x0004, mem_wdata=0x1234; ack1 pulses the following cycle; a subsequent port-0 read of 0x0004 returns 0x1234.
- Contention (macro undefined): req0 and req1 held high continuously → grants alternate 0,1,0,1 (gnt_id sequence); acks spaced MEM_LAT+2 cycles apart.
- Contention (macro defined): req0 and req1 held high for 4 transfers → 4 consecutive ack0, zero ack1; then drop req0 → ack1 follows.
- Latency parameter: MEM_LAT=3, read addr 0x0020 → mem_addr stable 3 cycles, ack0 at cycle 4 after sampling; mem_wmem never asserted.
- Reset mid-write: MEM_LAT=3, write started, RESET pulsed during the 2nd ACCESS cycle → mem_wmem never 1, no ack, memory unchanged; all outputs 0 during reset; next request served normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a single-port data memory between a CPU port (0) and a debug/DMA port (1).
// Define DMEM_ARB_CPU_PRIORITY_EN to give port 0 fixed priority instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_wmem,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          gnt_q, gnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          wmem_q, wmem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          win;
  logic          win_we;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
  logic          ptr_q, ptr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    gnt_d    = gnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wmem_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    win      = 1'b0;
    win_we   = 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
          win = ~req0;
`else
          // On a tie the port that did not win last time is granted.
          win   = (req0 && req1) ? ~ptr_q : req1;
          ptr_d = win;
`endif
          win_we  = win ? we1 : we0;
          gnt_d   = win;
          we_d    = win_we;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = CNT_INIT;
          wmem_d  = win_we && (CNT_INIT == '0);
          busy_d  = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (gnt_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          // Strobe is registered, so raise it one cycle ahead of the final ACCESS cycle.
          wmem_d = we_q && (cnt_q == 4'd1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wmem_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      ptr_q    <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wmem_q   <= wmem_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_wmem  = wmem_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized bench for dmem_arbiter.
// Instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3; each has its own memory.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [15:0] addr  [2][2];
  logic [15:0] wdata [2][2];
  logic        ack   [2][2];
  logic [15:0] rdata [2][2];
  logic        mem_wmem  [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        busy      [2];
  logic        gnt_id    [2];
  logic [15:0] mem [2][256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut_l1 (
    .CLK(CLK), .RESET(RESET),
    .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
    .ack0(ack[0][0]), .rdata0(rdata[0][0]),
    .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
    .ack1(ack[0][1]), .rdata1(rdata[0][1]),
    .mem_wmem(mem_wmem[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .gnt_id(gnt_id[0])
  );

  dmem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut_l3 (
    .CLK(CLK), .RESET(RESET),
    .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
    .ack0(ack[1][0]), .rdata0(rdata[1][0]),
    .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
    .ack1(ack[1][1]), .rdata1(rdata[1][1]),
    .mem_wmem(mem_wmem[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .gnt_id(gnt_id[1])
  );

  assign mem_rdata[0] = mem[0][mem_addr[0][7:0]];
  assign mem_rdata[1] = mem[1][mem_addr[1][7:0]];

  always @(posedge CLK) begin
    if (mem_wmem[0]) mem[0][mem_addr[0][7:0]] = mem_wdata[0];
    if (mem_wmem[1]) mem[1][mem_addr[1][7:0]] = mem_wdata[1];
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
      end
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [68:0] outs;
    idle_inputs();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      outs = {ack[d][0], ack[d][1], rdata[d][0], rdata[d][1], mem_wmem[d],
              mem_addr[d], mem_wdata[d], busy[d], gnt_id[d]};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got=%h exp=0", d, outs);
      end
    end
    step();
    RESET = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ack[d][0], ack[d][1], busy[d], mem_wmem[d]} !== 4'b0) begin
        errors++;
        $display("FAIL reset_idle inst=%0d got=%b exp=0000", d,
                 {ack[d][0], ack[d][1], busy[d], mem_wmem[d]});
      end
    end
  endtask

  task automatic test_single_read();
    mem[0][8'h10] = 16'hBEEF;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 16'h0010;
    step();
    checks++;
    if ({mem_addr[0], ack[0][0], busy[0], gnt_id[0]} !== {16'h0010, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL read_access got addr=%h ack=%b busy=%b gnt=%b exp addr=0010 ack=0 busy=1 gnt=0",
               mem_addr[0], ack[0][0], busy[0], gnt_id[0]);
    end
    step();
    checks++;
    if ({ack[0][0], ack[0][1], rdata[0][0]} !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL read_done got ack0=%b ack1=%b rdata0=%h exp 1 0 beef",
               ack[0][0], ack[0][1], rdata[0][0]);
    end
    req[0][0] = 1'b0;
    step();
    checks++;
    if ({ack[0][0], busy[0], rdata[0][0]} !== {1'b0, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL read_after got ack0=%b busy=%b rdata0=%h exp 0 0 beef",
               ack[0][0], busy[0], rdata[0][0]);
    end
  endtask

  task automatic test_single_write();
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 16'h0004; wdata[0][1] = 16'h1234;
    step();
    checks++;
    if ({mem_wmem[0], mem_addr[0], mem_wdata[0], ack[0][1], gnt_id[0]} !==
        {1'b1, 16'h0004, 16'h1234, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL write_strobe got wmem=%b addr=%h wdata=%h ack1=%b gnt=%b exp 1 0004 1234 0 1",
               mem_wmem[0], mem_addr[0], mem_wdata[0], ack[0][1], gnt_id[0]);
    end
    step();
    checks++;
    if ({mem_wmem[0], ack[0][1], ack[0][0], rdata[0][1]} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL write_done got wmem=%b ack1=%b ack0=%b rdata1=%h exp 0 1 0 0000",
               mem_wmem[0], ack[0][1], ack[0][0], rdata[0][1]);
    end
    req[0][1] = 1'b0; we[0][1] = 1'b0;
    step();
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 16'h0004;
    step();
    step();
    checks++;
    if ({ack[0][0], rdata[0][0]} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL write_readback got ack0=%b rdata0=%h exp 1 1234", ack[0][0], rdata[0][0]);
    end
    req[0][0] = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int nacks = 0;
    int c = 0;
    int last_c = 0;
    int exp_c;
    int exp_p;
    do_reset();
    req[0][0] = 1'b1; addr[0][0] = 16'h0040;
    req[0][1] = 1'b1; addr[0][1] = 16'h0041;
    while (nacks < 4 && c < 60) begin
      step();
      c++;
      if (ack[0][0] || ack[0][1]) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        exp_p = 0;
`else
        exp_p = nacks % 2;
`endif
        exp_c = (nacks == 0) ? 2 : last_c + 3;
        checks++;
        if (ack[0][exp_p] !== 1'b1 || ack[0][1-exp_p] !== 1'b0 || gnt_id[0] !== 1'(exp_p)) begin
          errors++;
          $display("FAIL contention_port n=%0d got ack0=%b ack1=%b gnt=%b exp port %0d",
                   nacks, ack[0][0], ack[0][1], gnt_id[0], exp_p);
        end
        checks++;
        if (c != exp_c) begin
          errors++;
          $display("FAIL contention_spacing n=%0d got cycle %0d exp %0d", nacks, c, exp_c);
        end
        last_c = c;
        nacks++;
      end
    end
    checks++;
    if (nacks != 4) begin
      errors++;
      $display("FAIL contention_timeout got %0d acks exp 4", nacks);
    end
    req[0][0] = 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
    req[0][1] = 1'b0;
`else
    begin
      int got_c = -1;
      for (int k = 1; k <= 10 && got_c < 0; k++) begin
        step();
        if (ack[0][1] === 1'b1) got_c = k;
        checks++;
        if (ack[0][0] !== 1'b0) begin
          errors++;
          $display("FAIL priority_no_ack0 got ack0=%b exp 0", ack[0][0]);
        end
      end
      checks++;
      if (got_c != 3) begin
        errors++;
        $display("FAIL priority_ack1 got cycle %0d exp 3", got_c);
      end
      req[0][1] = 1'b0;
    end
`endif
    step();
    step();
  endtask

  task automatic test_latency();
    mem[1][8'h20] = 16'h3C3C;
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 16'h0020;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({mem_addr[1], ack[1][0], mem_wmem[1]} !== {16'h0020, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL latency_access k=%0d got addr=%h ack0=%b wmem=%b exp 0020 0 0",
                 k, mem_addr[1], ack[1][0], mem_wmem[1]);
      end
    end
    step();
    checks++;
    if ({ack[1][0], rdata[1][0], mem_wmem[1]} !== {1'b1, 16'h3C3C, 1'b0}) begin
      errors++;
      $display("FAIL latency_done got ack0=%b rdata0=%h wmem=%b exp 1 3c3c 0",
               ack[1][0], rdata[1][0], mem_wmem[1]);
    end
    req[1][0] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_write();
    logic [68:0] outs;
    mem[1][8'h30] = 16'h5555;
    req[1][0] = 1'b1; we[1][0] = 1'b1; addr[1][0] = 16'h0030; wdata[1][0] = 16'hAAAA;
    step();
    step();
    checks++;
    if ({mem_wmem[1], busy[1]} !== 2'b01) begin
      errors++;
      $display("FAIL rstw_access got wmem=%b busy=%b exp 0 1", mem_wmem[1], busy[1]);
    end
    RESET = 1'b1;
    #1;
    outs = {ack[1][0], ack[1][1], rdata[1][0], rdata[1][1], mem_wmem[1],
            mem_addr[1], mem_wdata[1], busy[1], gnt_id[1]};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rstw_outputs got=%h exp=0", outs);
    end
    req[1][0] = 1'b0; we[1][0] = 1'b0;
    step();
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({ack[1][0], ack[1][1], mem_wmem[1]} !== 3'b000) begin
        errors++;
        $display("FAIL rstw_quiet k=%0d got ack0=%b ack1=%b wmem=%b exp 000",
                 k, ack[1][0], ack[1][1], mem_wmem[1]);
      end
    end
    checks++;
    if (mem[1][8'h30] !== 16'h5555) begin
      errors++;
      $display("FAIL rstw_mem got %h exp 5555", mem[1][8'h30]);
    end
    req[1][0] = 1'b1; addr[1][0] = 16'h0030;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if ({ack[1][0], rdata[1][0]} !== {1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL rstw_next got ack0=%b rdata0=%h exp 1 5555", ack[1][0], rdata[1][0]);
    end
    req[1][0] = 1'b0;
    step();
  endtask

  // Timeline reference: an arbiter idle in cycle c grants at the end of c, acks in c+L+1.
  task automatic test_random(input int d, input int L, input int ncyc);
    logic [15:0] ref_mem [256];
    logic        act [2];
    logic        gnt [2];
    int          gap [2];
    logic        t_we [2];
    logic [15:0] t_addr [2];
    logic [15:0] t_wd [2];
    logic [15:0] exp_rd [2];
    logic        exp_gnt = 1'b0;
    int          last = 1;
    int          gcyc = -1;
    int          ack_cyc = -1;
    int          wp = 0;
    logic        wwe = 1'b0;
    logic [15:0] waddr = '0;
    logic [15:0] wwd = '0;
    logic [15:0] pend_rd = '0;
    logic        exp_a, exp_wm, exp_busy, mem_ok;
    int          w;
    int          drain = 3 * (L + 2) + 4;

    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[d][i];
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; gnt[p] = 1'b0; gap[p] = 0; exp_rd[p] = '0;
      t_we[p] = 1'b0; t_addr[p] = '0; t_wd[p] = '0;
    end

    for (int c = 0; c < ncyc; c++) begin
      if (c == ack_cyc && !wwe) exp_rd[wp] = pend_rd;
      for (int p = 0; p < 2; p++) begin
        exp_a = (c == ack_cyc) && (wp == p);
        checks++;
        if (ack[d][p] !== exp_a || rdata[d][p] !== exp_rd[p]) begin
          errors++;
          $display("FAIL rand_ack inst=%0d c=%0d port=%0d got ack=%b rdata=%h exp ack=%b rdata=%h",
                   d, c, p, ack[d][p], rdata[d][p], exp_a, exp_rd[p]);
        end
      end
      exp_wm   = wwe && (c == ack_cyc - 1);
      exp_busy = (c > gcyc) && (c <= ack_cyc);
      checks++;
      if (mem_wmem[d] !== exp_wm || busy[d] !== exp_busy || gnt_id[d] !== exp_gnt ||
          (exp_wm && (mem_addr[d] !== waddr || mem_wdata[d] !== wwd))) begin
        errors++;
        $display("FAIL rand_mem inst=%0d c=%0d got wmem=%b busy=%b gnt=%b addr=%h wdata=%h exp wmem=%b busy=%b gnt=%b addr=%h wdata=%h",
                 d, c, mem_wmem[d], busy[d], gnt_id[d], mem_addr[d], mem_wdata[d],
                 exp_wm, exp_busy, exp_gnt, waddr, wwd);
      end

      for (int p = 0; p < 2; p++) begin
        if (c == ack_cyc && wp == p) begin
          act[p] = 1'b0; gnt[p] = 1'b0; req[d][p] = 1'b0;
          gap[p] = int'($urandom_range(0, 2));
        end else if (act[p]) begin
          if (gnt[p]) begin
            if ($urandom_range(0, 3) == 0) begin
              we[d][p]    = 1'($urandom_range(0, 1));
              addr[d][p]  = 16'($urandom);
              wdata[d][p] = 16'($urandom);
              req[d][p]   = 1'($urandom_range(0, 1));
            end
          end else if ($urandom_range(0, 15) == 0) begin
            act[p] = 1'b0; req[d][p] = 1'b0; gap[p] = 1;
          end
        end else if (gap[p] > 0) begin
          gap[p]--;
        end else if (c < ncyc - drain && $urandom_range(0, 1) == 1) begin
          act[p]    = 1'b1;
          t_we[p]   = 1'($urandom_range(0, 1));
          t_addr[p] = 16'($urandom);
          t_wd[p]   = 16'($urandom);
          req[d][p] = 1'b1; we[d][p] = t_we[p]; addr[d][p] = t_addr[p]; wdata[d][p] = t_wd[p];
        end
      end

      if (c > ack_cyc && (act[0] || act[1])) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        w = act[0] ? 0 : 1;
`else
        if (act[0] && act[1]) w = (last == 0) ? 1 : 0;
        else                  w = act[0] ? 0 : 1;
        last = w;
`endif
        gnt[w]  = 1'b1;
        exp_gnt = 1'(w);
        gcyc    = c;
        ack_cyc = c + L + 1;
        wp      = w;
        wwe     = t_we[w];
        waddr   = t_addr[w];
        wwd     = t_wd[w];
        if (wwe) ref_mem[waddr[7:0]] = wwd;
        else     pend_rd = ref_mem[waddr[7:0]];
      end
      step();
    end

    idle_inputs();
    step();
    mem_ok = 1'b1;
    for (int i = 0; i < 256; i++) if (mem[d][i] !== ref_mem[i]) mem_ok = 1'b0;
    checks++;
    if (!mem_ok) begin
      errors++;
      $display("FAIL rand_memory inst=%0d got contents differ exp model contents", d);
    end
  endtask

  initial begin
    idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mem[d][i] = 16'($urandom);
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_latency();
    test_reset_mid_write();
    test_random(0, 1, 400);
    test_random(1, 3, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "bench timeout");
  end

endmodule
